// File: rtl/abus_pkg.sv
// Shared types and constants for the abus DMA engine.
// Provides the DMA state enum, error codes and the strb/keep width helper.
package abus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_ABORT,
        ST_FINISH
    } dma_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_STOP    = 2'd3;

    function automatic int sk_size(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/abus_dma_watchdog.sv
// Per-order watchdog: reloads on clear, counts down while enabled.
// Ports: abus_clk, abus_rstb, clear, enable in; expired out.
module abus_dma_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic abus_clk,
    input  logic abus_rstb,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // Loaded with TIMEOUT-1 so expiry is flagged in the TIMEOUT-th
    // waiting cycle, letting the follow-up abort land exactly
    // TIMEOUT cycles after the order pulse.
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (enable && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/abus_dma.sv
// Single-channel word-copy DMA in front of abus_master.
// Ports: start/src_addr/dst_addr/length/stop control; busy, irq_done,
// irq_err, err_code, count status; write/read/abort/address/wdata/strb/
// keep order interface; rdata/new_rdata/done/err master status.
module abus_dma
    import abus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int ADDR_STEP  = 1,
    parameter int TIMEOUT    = 255,
    localparam int SK_SIZE   = sk_size(DATA_WIDTH)
) (
    input  logic                  abus_clk,
    input  logic                  abus_rstb,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  stop,
    output logic                  busy,
    output logic                  irq_done,
    output logic                  irq_err,
    output logic [1:0]            err_code,
    output logic [LEN_WIDTH-1:0]  count,
    output logic                  write,
    output logic                  read,
    output logic                  abort,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [SK_SIZE-1:0]    strb,
    output logic [SK_SIZE-1:0]    keep,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  new_rdata,
    input  logic                  done,
    input  logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    dma_state_t state, state_n;

    logic                  busy_n, irq_done_n, irq_err_n;
    logic [1:0]            err_n;
    logic [LEN_WIDTH-1:0]  count_n, count_inc;
    logic                  write_n, read_n, abort_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [ADDR_WIDTH-1:0] src_ptr, src_n, dst_ptr, dst_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic                  have_data, have_n;
    // A stop that coincided with done is carried into the next state.
    logic                  stop_pend, pend_n;
    logic                  wd_clear, wd_enable, wd_expired;

    assign strb = '0;
    assign keep = '1;

    assign count_inc = count + LEN_WIDTH'(1);

    assign wd_clear  = read_n | write_n | abort_n;
    assign wd_enable = (state == ST_RD_WAIT) || (state == ST_WR_WAIT) ||
                       (state == ST_ABORT);

    abus_dma_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .abus_clk  (abus_clk),
        .abus_rstb (abus_rstb),
        .clear     (wd_clear),
        .enable    (wd_enable),
        .expired   (wd_expired)
    );

    always_comb begin
        state_n    = state;
        busy_n     = busy;
        irq_done_n = 1'b0;
        irq_err_n  = 1'b0;
        err_n      = err_code;
        count_n    = count;
        write_n    = 1'b0;
        read_n     = 1'b0;
        abort_n    = 1'b0;
        addr_n     = address;
        wdata_n    = wdata;
        src_n      = src_ptr;
        dst_n      = dst_ptr;
        len_n      = len_q;
        data_n     = data_q;
        have_n     = have_data;
        pend_n     = stop_pend;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    src_n   = src_addr;
                    dst_n   = dst_addr;
                    len_n   = length;
                    count_n = '0;
                    err_n   = ERR_NONE;
                    busy_n  = 1'b1;
                    have_n  = 1'b0;
                    pend_n  = 1'b0;
                    state_n = (length == '0) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (stop || stop_pend) begin
                    err_n   = ERR_STOP;
                    pend_n  = 1'b0;
                    state_n = ST_FINISH;
                end else begin
                    read_n  = 1'b1;
                    addr_n  = src_ptr;
                    have_n  = 1'b0;
                    state_n = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (new_rdata) begin
                    data_n = rdata;
                    have_n = 1'b1;
                end
                if (err) begin
                    err_n   = ERR_BUS;
                    state_n = ST_FINISH;
                end else if (done) begin
                    if (have_data || new_rdata) begin
                        pend_n  = stop;
                        state_n = ST_WR_REQ;
                    end else begin
                        err_n   = ERR_BUS;
                        state_n = ST_FINISH;
                    end
                end else if (wd_expired) begin
                    err_n   = ERR_TIMEOUT;
                    abort_n = 1'b1;
                    state_n = ST_ABORT;
                end else if (stop) begin
                    err_n   = ERR_STOP;
                    abort_n = 1'b1;
                    state_n = ST_ABORT;
                end
            end
            ST_WR_REQ: begin
                if (stop || stop_pend) begin
                    err_n   = ERR_STOP;
                    pend_n  = 1'b0;
                    state_n = ST_FINISH;
                end else begin
                    write_n = 1'b1;
                    addr_n  = dst_ptr;
                    wdata_n = data_q;
                    state_n = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (err) begin
                    err_n   = ERR_BUS;
                    state_n = ST_FINISH;
                end else if (done) begin
                    count_n = count_inc;
                    src_n   = src_ptr + STEP;
                    dst_n   = dst_ptr + STEP;
                    if (count_inc == len_q) begin
                        pend_n  = 1'b0;
                        state_n = ST_FINISH;
                    end else begin
                        pend_n  = stop;
                        state_n = ST_RD_REQ;
                    end
                end else if (wd_expired) begin
                    err_n   = ERR_TIMEOUT;
                    abort_n = 1'b1;
                    state_n = ST_ABORT;
                end else if (stop) begin
                    err_n   = ERR_STOP;
                    abort_n = 1'b1;
                    state_n = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (err || done || wd_expired) begin
                    state_n = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy_n     = 1'b0;
                irq_done_n = (err_code == ERR_NONE);
                irq_err_n  = (err_code != ERR_NONE);
                state_n    = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge abus_clk or negedge abus_rstb) begin
        if (!abus_rstb) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            irq_done  <= 1'b0;
            irq_err   <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
            write     <= 1'b0;
            read      <= 1'b0;
            abort     <= 1'b0;
            address   <= '0;
            wdata     <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            len_q     <= '0;
            data_q    <= '0;
            have_data <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_n;
            busy      <= busy_n;
            irq_done  <= irq_done_n;
            irq_err   <= irq_err_n;
            err_code  <= err_n;
            count     <= count_n;
            write     <= write_n;
            read      <= read_n;
            abort     <= abort_n;
            address   <= addr_n;
            wdata     <= wdata_n;
            src_ptr   <= src_n;
            dst_ptr   <= dst_n;
            len_q     <= len_n;
            data_q    <= data_n;
            have_data <= have_n;
            stop_pend <= pend_n;
        end
    end

endmodule

// File: tb/tb_abus_dma.sv
// Directed testbench for abus_dma with a simple abus slave/SRAM model.
// Each scenario task drives stimulus and checks its own results.
module tb_abus_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [7:0]  length = '0;
    logic        stop = 1'b0;
    logic        busy, irq_done, irq_err;
    logic [1:0]  err_code;
    logic [7:0]  count;
    logic        write, read, abort;
    logic [15:0] address, wdata;
    logic [4:0]  strb, keep;
    logic [15:0] rdata = '0;
    logic        new_rdata = 1'b0;
    logic        done = 1'b0;
    logic        err = 1'b0;

    int checks = 0;
    int failures = 0;

    abus_dma #(
        .TIMEOUT (8)
    ) dut (
        .abus_clk  (clk),
        .abus_rstb (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .stop      (stop),
        .busy      (busy),
        .irq_done  (irq_done),
        .irq_err   (irq_err),
        .err_code  (err_code),
        .count     (count),
        .write     (write),
        .read      (read),
        .abort     (abort),
        .address   (address),
        .wdata     (wdata),
        .strb      (strb),
        .keep      (keep),
        .rdata     (rdata),
        .new_rdata (new_rdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] sram [0:65535];

    // slave model controls
    int slave_delay = 0;
    int err_read = 0;
    bit no_ack = 0;

    int          rd_seen = 0;
    bit          pend = 0;
    int          pend_kind = 0;
    logic [15:0] pend_addr = '0;
    logic [15:0] pend_data = '0;
    int          wait_cnt = 0;
    int          wdone_cyc [0:15];
    int          wdone_n = 0;

    // Orders are answered on negedges so responses are stable at posedge.
    always @(negedge clk) begin
        done = 1'b0;
        new_rdata = 1'b0;
        err = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (wait_cnt == 0) begin
                    pend = 0;
                    if (pend_kind == 0) begin
                        rd_seen++;
                        if (rd_seen == err_read) begin
                            err = 1'b1;
                        end else begin
                            rdata = sram[pend_addr];
                            new_rdata = 1'b1;
                            done = 1'b1;
                        end
                    end else if (pend_kind == 1) begin
                        sram[pend_addr] = pend_data;
                        done = 1'b1;
                        if (wdone_n < 16) wdone_cyc[wdone_n] = cyc;
                        wdone_n++;
                    end else begin
                        done = 1'b1;
                    end
                end else begin
                    wait_cnt--;
                end
            end
            if (abort) begin
                pend = 1; pend_kind = 2; wait_cnt = slave_delay;
            end else if ((read || write) && !no_ack) begin
                pend = 1;
                pend_kind = read ? 0 : 1;
                pend_addr = address;
                pend_data = wdata;
                wait_cnt = slave_delay;
            end
        end
    end

    // pulse monitor
    int          rd_pulses = 0, wr_pulses = 0, ab_pulses = 0;
    int          irq_done_cnt = 0, irq_err_cnt = 0, busy_cyc = 0;
    int          rd_cyc [0:15];
    logic [15:0] rd_addr [0:15];
    int          ab_cyc = 0, irq_cyc = 0, start_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (read) begin
                if (rd_pulses < 16) begin
                    rd_cyc[rd_pulses] = cyc;
                    rd_addr[rd_pulses] = address;
                end
                rd_pulses++;
            end
            if (write) wr_pulses++;
            if (abort) begin
                ab_pulses++;
                ab_cyc = cyc;
            end
            if (irq_done) begin
                irq_done_cnt++;
                irq_cyc = cyc;
            end
            if (irq_err) begin
                irq_err_cnt++;
                irq_cyc = cyc;
            end
            if (busy) busy_cyc++;
        end
    end

    task automatic clr_mon();
        rd_pulses = 0; wr_pulses = 0; ab_pulses = 0;
        irq_done_cnt = 0; irq_err_cnt = 0; busy_cyc = 0;
        rd_seen = 0; wdone_n = 0;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d,
                            input logic [7:0] n);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = n;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while ((irq_done_cnt + irq_err_cnt) == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL %s_irq_timeout got=none exp=irq", name);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, irq_done, irq_err, write, read, abort} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy, irq_done, irq_err, write, read, abort});
        end
        checks++;
        if (address !== 16'h0 || wdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h/%h exp=0000/0000", address, wdata);
        end
        checks++;
        if (count !== 8'h0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL reset_status got=%0d/%0d exp=0/0", count, err_code);
        end
        checks++;
        if (strb !== 5'h00 || keep !== 5'h1F) begin
            failures++;
            $display("FAIL tieoffs got=%h/%h exp=00/1f", strb, keep);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_copy();
        sram[16'h0010] = 16'hCAFE;
        sram[16'h0011] = 16'hBEEF;
        sram[16'h0012] = 16'h1234;
        clr_mon();
        do_start(16'h0010, 16'h0100, 8'd3);
        wait_irq("copy");
        checks++;
        if (sram[16'h0100] !== 16'hCAFE || sram[16'h0101] !== 16'hBEEF ||
            sram[16'h0102] !== 16'h1234) begin
            failures++;
            $display("FAIL copy_data got=%h %h %h exp=cafe beef 1234",
                     sram[16'h0100], sram[16'h0101], sram[16'h0102]);
        end
        checks++;
        if (count !== 8'd3 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL copy_status got=%0d/%0d exp=3/0", count, err_code);
        end
        checks++;
        if (rd_pulses != 3 || wr_pulses != 3) begin
            failures++;
            $display("FAIL copy_pulses got=%0d/%0d exp=3/3", rd_pulses, wr_pulses);
        end
        checks++;
        if (irq_done_cnt != 1 || irq_err_cnt != 0) begin
            failures++;
            $display("FAIL copy_irq got=%0d/%0d exp=1/0", irq_done_cnt, irq_err_cnt);
        end
        checks++;
        if (rd_cyc[0] - start_cyc != 2) begin
            failures++;
            $display("FAIL copy_start_lat got=%0d exp=2", rd_cyc[0] - start_cyc);
        end
        checks++;
        if (rd_cyc[1] - wdone_cyc[0] != 2) begin
            failures++;
            $display("FAIL copy_next_rd_lat got=%0d exp=2", rd_cyc[1] - wdone_cyc[0]);
        end
        checks++;
        if (irq_cyc - wdone_cyc[2] != 2) begin
            failures++;
            $display("FAIL copy_irq_lat got=%0d exp=2", irq_cyc - wdone_cyc[2]);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL copy_busy_end got=%b exp=0", busy);
        end
    endtask

    task automatic test_len_zero();
        clr_mon();
        do_start(16'h0020, 16'h0200, 8'd0);
        wait_irq("len0");
        checks++;
        if (rd_pulses != 0 || wr_pulses != 0) begin
            failures++;
            $display("FAIL len0_pulses got=%0d/%0d exp=0/0", rd_pulses, wr_pulses);
        end
        checks++;
        if (busy_cyc != 1) begin
            failures++;
            $display("FAIL len0_busy got=%0d exp=1", busy_cyc);
        end
        checks++;
        if (irq_done_cnt != 1 || irq_cyc - start_cyc != 2) begin
            failures++;
            $display("FAIL len0_irq got=%0d@%0d exp=1@2", irq_done_cnt,
                     irq_cyc - start_cyc);
        end
    endtask

    task automatic test_bus_err();
        clr_mon();
        err_read = 2;
        do_start(16'h0010, 16'h0300, 8'd3);
        wait_irq("buserr");
        repeat (10) @(negedge clk);
        err_read = 0;
        checks++;
        if (irq_err_cnt != 1 || irq_done_cnt != 0) begin
            failures++;
            $display("FAIL buserr_irq got=%0d/%0d exp=1/0", irq_err_cnt, irq_done_cnt);
        end
        checks++;
        if (err_code !== 2'd1 || count !== 8'd1) begin
            failures++;
            $display("FAIL buserr_status got=%0d/%0d exp=1/1", err_code, count);
        end
        checks++;
        if (rd_pulses != 2 || wr_pulses != 1 || ab_pulses != 0) begin
            failures++;
            $display("FAIL buserr_pulses got=%0d/%0d/%0d exp=2/1/0",
                     rd_pulses, wr_pulses, ab_pulses);
        end
    endtask

    task automatic test_timeout();
        clr_mon();
        no_ack = 1;
        slave_delay = 1;
        do_start(16'h0010, 16'h0300, 8'd1);
        wait_irq("timeout");
        no_ack = 0;
        slave_delay = 0;
        checks++;
        if (ab_pulses != 1 || ab_cyc - rd_cyc[0] != 8) begin
            failures++;
            $display("FAIL timeout_abort got=%0d@%0d exp=1@8", ab_pulses,
                     ab_cyc - rd_cyc[0]);
        end
        checks++;
        if (irq_err_cnt != 1 || err_code !== 2'd2 || count !== 8'd0) begin
            failures++;
            $display("FAIL timeout_status got=%0d/%0d/%0d exp=1/2/0",
                     irq_err_cnt, err_code, count);
        end
    endtask

    task automatic test_stop();
        int n = 0;
        int wcnt = 0;
        int wcyc = 0;
        clr_mon();
        slave_delay = 3;
        do_start(16'h0010, 16'h0500, 8'd4);
        do_start(16'h0020, 16'h0600, 8'd0);
        while (wcnt < 2 && n < 300) begin
            @(negedge clk);
            n++;
            if (write === 1'b1) wcnt++;
        end
        checks++;
        if (wcnt != 2) begin
            failures++;
            $display("FAIL stop_second_write got=%0d exp=2", wcnt);
        end
        wcyc = cyc;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_irq("stop");
        slave_delay = 0;
        checks++;
        if (ab_pulses != 1 || ab_cyc - wcyc != 1) begin
            failures++;
            $display("FAIL stop_abort got=%0d@%0d exp=1@1", ab_pulses, ab_cyc - wcyc);
        end
        checks++;
        if (irq_err_cnt != 1 || irq_done_cnt != 0) begin
            failures++;
            $display("FAIL stop_irq got=%0d/%0d exp=1/0", irq_err_cnt, irq_done_cnt);
        end
        checks++;
        if (err_code !== 2'd3 || count !== 8'd1) begin
            failures++;
            $display("FAIL stop_status got=%0d/%0d exp=3/1", err_code, count);
        end
    endtask

    task automatic test_wrap_reset();
        int n = 0;
        sram[16'hFFFF] = 16'hA5A5;
        sram[16'h0000] = 16'h5A5A;
        clr_mon();
        do_start(16'hFFFF, 16'h0200, 8'd2);
        wait_irq("wrap");
        checks++;
        if (rd_addr[1] !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_addr got=%h exp=0000", rd_addr[1]);
        end
        checks++;
        if (sram[16'h0200] !== 16'hA5A5 || sram[16'h0201] !== 16'h5A5A) begin
            failures++;
            $display("FAIL wrap_data got=%h %h exp=a5a5 5a5a",
                     sram[16'h0200], sram[16'h0201]);
        end
        clr_mon();
        do_start(16'h0010, 16'h0300, 8'd3);
        while (rd_pulses < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, irq_done, irq_err, write, read, abort} !== 6'b0 ||
            address !== 16'h0 || wdata !== 16'h0 ||
            count !== 8'h0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL midreset got=%b %h %h %0d %0d exp=0",
                     {busy, irq_done, irq_err, write, read, abort},
                     address, wdata, count, err_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clr_mon();
        do_start(16'h0011, 16'h0400, 8'd1);
        wait_irq("restart");
        checks++;
        if (sram[16'h0400] !== 16'hBEEF || irq_done_cnt != 1 || count !== 8'd1) begin
            failures++;
            $display("FAIL restart got=%h/%0d/%0d exp=beef/1/1",
                     sram[16'h0400], irq_done_cnt, count);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_len_zero();
        test_bus_err();
        test_timeout();
        test_stop();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
